l2_req_fifo: RTL and testbench

- Request queue between the L2 cache memory-request port and the L2-to-AXI bridge.
- Buffers up to `depth` line-sized memory requests so the L2 can post evictions and refills while the bridge is busy with a burst or waiting for a write ack.
- Preserves strict request order.
- Provides a line-address lookup so the L2 can detect a pending write to a line it is about to re-fetch.

---
 rtl/l2_req_fifo.sv | 106 ++++++++++
 tb/tb_l2_req_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_fifo.sv
// In-order request queue between the L2 memory-request port and the L2-to-AXI bridge,
// with a line-address lookup over queued writes.
module l2_req_fifo #(
  parameter int unsigned abits = 48,
  parameter int unsigned lbits = 256,
  parameter int unsigned depth = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [2:0]                 i_req_type,
  input  logic [abits-1:0]           i_req_addr,
  input  logic [2:0]                 i_req_size,
  input  logic [lbits/8-1:0]         i_req_strob,
  input  logic [lbits-1:0]           i_req_data,
  output logic                       o_mem_valid,
  input  logic                       i_mem_ready,
  output logic [2:0]                 o_mem_type,
  output logic [abits-1:0]           o_mem_addr,
  output logic [2:0]                 o_mem_size,
  output logic [lbits/8-1:0]         o_mem_strob,
  output logic [lbits-1:0]           o_mem_data,
  input  logic [abits-1:0]           i_lookup_addr,
  output logic                       o_lookup_hit,
  output logic [$clog2(depth):0]     o_count
);

  localparam int unsigned sbits = lbits / 8;
  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;
  localparam int unsigned off_w = $clog2(sbits);
  localparam logic [abits-1:0] line_mask = {abits{1'b1}} << off_w;

  typedef struct packed {
    logic [2:0]       typ;
    logic [abits-1:0] addr;
    logic [2:0]       size;
    logic [sbits-1:0] strob;
    logic [lbits-1:0] data;
  } req_t;

  req_t             mem [depth];
  req_t             head;
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic             push_c;
  logic             pop_c;
  logic [depth-1:0] occ_c;
  logic [depth-1:0] wmatch_c;

  // Flags come from registered count only, so ready never depends on i_mem_ready.
  assign o_req_ready = (count != cnt_w'(depth));
  assign o_mem_valid = (count != '0);
  assign push_c      = i_req_valid && o_req_ready;
  assign pop_c       = o_mem_valid && i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{typ: i_req_type, addr: i_req_addr, size: i_req_size,
                       strob: i_req_strob, data: i_req_data};
    end
  end

  assign head        = mem[rd_ptr];
  assign o_mem_type  = head.typ;
  assign o_mem_addr  = head.addr;
  assign o_mem_size  = head.size;
  assign o_mem_strob = head.strob;
  assign o_mem_data  = head.data;
  assign o_count     = count;

  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    logic [ptr_w-1:0] off;
    off      = '0;
    occ_c    = '0;
    wmatch_c = '0;
    for (int unsigned i = 0; i < depth; i++) begin
      off         = ptr_w'(i) - rd_ptr;
      occ_c[i]    = ({1'b0, off} < count);
      wmatch_c[i] = mem[i].typ[0] && (((mem[i].addr ^ i_lookup_addr) & line_mask) == '0);
    end
  end

  assign o_lookup_hit = |(occ_c & wmatch_c);

endmodule

// File: tb/tb_l2_req_fifo.sv
// Directed bench for l2_req_fifo: reset, pass-through, fill/order, concurrent
// push/pop with pointer wrap, line lookup and mid-operation reset.
module tb_l2_req_fifo;

  localparam int unsigned ABITS = 48;
  localparam int unsigned LBITS = 256;
  localparam int unsigned SBITS = LBITS / 8;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_type;
  logic [ABITS-1:0] req_addr;
  logic [2:0]       req_size;
  logic [SBITS-1:0] req_strob;
  logic [LBITS-1:0] req_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [2:0]       mem_type;
  logic [ABITS-1:0] mem_addr;
  logic [2:0]       mem_size;
  logic [SBITS-1:0] mem_strob;
  logic [LBITS-1:0] mem_data;
  logic [ABITS-1:0] lookup_addr;
  logic             lookup_hit;
  logic [2:0]       count;

  int vectors     = 0;
  int miscompares = 0;

  l2_req_fifo #(.abits(ABITS), .lbits(LBITS), .depth(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_type(req_type), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_strob(req_strob), .i_req_data(req_data),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready),
    .o_mem_type(mem_type), .o_mem_addr(mem_addr), .o_mem_size(mem_size),
    .o_mem_strob(mem_strob), .o_mem_data(mem_data),
    .i_lookup_addr(lookup_addr), .o_lookup_hit(lookup_hit), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LBITS-1:0] rep(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [ABITS-1:0] a, input logic [LBITS-1:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_size  = 3'd5;
    req_strob = {SBITS{t[0]}};
    req_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0; lookup_addr = '0;
    req_type = '0; req_addr = '0; req_size = '0; req_strob = '0; req_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", mem_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (lookup_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b exp 0", lookup_hit); end
  endtask

  task automatic test_pass_through();
    drive(3'b010, 48'h0000_8000_0040, '0);
    step();
    req_valid = 1'b0;
    vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("FAIL pt_valid got %b exp 1", mem_valid); end
    vectors++; if (mem_type !== 3'b010) begin miscompares++; $display("FAIL pt_type got %b exp 010", mem_type); end
    vectors++; if (mem_addr !== 48'h0000_8000_0040) begin miscompares++; $display("FAIL pt_addr got %h exp 000080000040", mem_addr); end
    vectors++; if (mem_size !== 3'd5) begin miscompares++; $display("FAIL pt_size got %0d exp 5", mem_size); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL pt_count got %0d exp 1", count); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL pt_count_after got %0d exp 0", count); end
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL pt_valid_after got %b exp 0", mem_valid); end
  endtask

  task automatic test_fill_and_order();
    logic [31:0] words [5];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444; words[4] = 32'h5555_5555;
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(3'b011, ABITS'(32'h1000 + k * 32'h40), rep(words[k]));
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_%0d got %b exp 1", k, req_ready); end
      step();
    end
    drive(3'b011, ABITS'(32'h1100), rep(words[4]));
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b exp 0", req_ready); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", count); end
    step();
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_reject got %0d exp 4", count); end
    vectors++; if (mem_data !== rep(words[0])) begin miscompares++; $display("FAIL stall_head got %h exp %h", mem_data, rep(words[0])); end
    // Pop while full: the pending fifth push must not slip in on this edge.
    mem_ready = 1'b1;
    step();
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL pop_while_full got %0d exp 3", count); end
    vectors++; if (mem_data !== rep(words[1])) begin miscompares++; $display("FAIL order_1 got %h exp %h", mem_data, rep(words[1])); end
    step();
    req_valid = 1'b0;
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL fifth_accept got %0d exp 3", count); end
    for (int k = 2; k < 5; k++) begin
      vectors++; if (mem_data !== rep(words[k])) begin miscompares++; $display("FAIL order_%0d got %h exp %h", k, mem_data, rep(words[k])); end
      step();
    end
    mem_ready = 1'b0;
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got %b exp 0", mem_valid); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    drive(3'b001, ABITS'(32'h4000), rep(32'hA500_0000));
    step();
    drive(3'b001, ABITS'(32'h4040), rep(32'hA500_0001));
    step();
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(3'b001, ABITS'(32'h4000 + (k + 2) * 32'h40), rep(32'hA500_0000 + 32'(k + 2)));
      vectors++; if (mem_data !== rep(32'hA500_0000 + 32'(k))) begin miscompares++; $display("FAIL b2b_head_%0d got %h exp %h", k, mem_data, rep(32'hA500_0000 + 32'(k))); end
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL b2b_count_%0d got %0d exp 2", k, count); end
      step();
    end
    req_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      vectors++; if (mem_data !== rep(32'hA500_0000 + 32'(k))) begin miscompares++; $display("FAIL b2b_tail_%0d got %h exp %h", k, mem_data, rep(32'hA500_0000 + 32'(k))); end
      step();
    end
    mem_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL b2b_empty got %0d exp 0", count); end
  endtask

  task automatic test_lookup();
    mem_ready = 1'b0;
    drive(3'b001, ABITS'(32'h1000), rep(32'hDEAD_BEEF));
    lookup_addr = ABITS'(32'h1000);
    #1;
    vectors++; if (lookup_hit !== 1'b0) begin miscompares++; $display("FAIL lk_pushing got %b exp 0", lookup_hit); end
    step();
    drive(3'b000, ABITS'(32'h2000), '0);
    lookup_addr = ABITS'(32'h101F);
    #1;
    vectors++; if (lookup_hit !== 1'b1) begin miscompares++; $display("FAIL lk_same_line got %b exp 1", lookup_hit); end
    step();
    req_valid = 1'b0;
    lookup_addr = ABITS'(32'h1020);
    #1;
    vectors++; if (lookup_hit !== 1'b0) begin miscompares++; $display("FAIL lk_next_line got %b exp 0", lookup_hit); end
    lookup_addr = ABITS'(32'h2000);
    #1;
    vectors++; if (lookup_hit !== 1'b0) begin miscompares++; $display("FAIL lk_read_entry got %b exp 0", lookup_hit); end
    lookup_addr = ABITS'(32'h1000);
    mem_ready = 1'b1;
    #1;
    vectors++; if (lookup_hit !== 1'b1) begin miscompares++; $display("FAIL lk_popping got %b exp 1", lookup_hit); end
    step();
    mem_ready = 1'b0;
    #1;
    vectors++; if (lookup_hit !== 1'b0) begin miscompares++; $display("FAIL lk_after_pop got %b exp 0", lookup_hit); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    lookup_addr = '0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL lk_drain got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(3'b011, ABITS'(32'h8000 + k * 32'h40), rep(32'hE000_0000 + 32'(k)));
      step();
    end
    req_valid = 1'b0;
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL rm_before got %0d exp 3", count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rm_count got %0d exp 0", count); end
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL rm_valid got %b exp 0", mem_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready got %b exp 1", req_ready); end
    lookup_addr = ABITS'(32'h8000);
    #1;
    vectors++; if (lookup_hit !== 1'b0) begin miscompares++; $display("FAIL rm_hit got %b exp 0", lookup_hit); end
    drive(3'b010, ABITS'(32'hC000), rep(32'hF00D_F00D));
    step();
    req_valid = 1'b0;
    vectors++; if (mem_data !== rep(32'hF00D_F00D)) begin miscompares++; $display("FAIL rm_new_head got %h exp %h", mem_data, rep(32'hF00D_F00D)); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL rm_new_count got %0d exp 1", count); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL rm_no_stale got %b exp 0", mem_valid); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_and_order();
    test_back_to_back();
    test_lookup();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
